scan_sequencer: RTL and testbench

//   Upstream driver for the active-low 4-to-16 line decoder. Steps a 4-bit line

---
 rtl/scan_sequencer_pkg.sv | 22 ++
 rtl/scan_next_idx.sv | 26 ++
 rtl/scan_sequencer.sv | 148 ++++++++++++++
 tb/tb_scan_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer: state encoding and line geometry.
// No logic here, so it adds no latency.
// No flow control here; the helper below only sizes the counters.
package scan_sequencer_pkg;

  // Scan FSM state encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  localparam int IDX_W = 4;   // decoder index width
  localparam int LINES = 16;  // decoder output count

  // Width of a counter that must hold values 0..n.
  // A zero-length count still gets one bit so no vector is declared with zero width.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_next_idx.sv
// Finds the lowest set mask bit strictly above cur, or from bit 0 when from_zero=1.
// Purely combinational, so the result is ready in the same cycle.
// No flow control: the outputs simply follow the inputs.
module scan_next_idx
  import scan_sequencer_pkg::*;
(
  input  logic [LINES-1:0] mask,
  input  logic [IDX_W-1:0] cur,
  input  logic             from_zero,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Search from the top down so that the last hit, which wins, is the lowest eligible bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (mask[i] && (from_zero || (i > int'(cur)))) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Steps the decoder index over the masked lines: DWELL cycles with en_n low, then GAP blank cycles.
// en_n goes low in the cycle after start is sampled; all outputs are registered.
// There is no backpressure. start is ignored while busy, and stop aborts the scan in the next cycle.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [LINES-1:0] mask,
  output logic             en_n,
  output logic [IDX_W-1:0] sel,
  output logic             busy,
  output logic             done
);

  localparam int DW_W = cnt_width(DWELL);
  localparam int GW_W = cnt_width(GAP);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [GW_W-1:0] GAP_LAST   = GW_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state;
  logic [DW_W-1:0]  dwell_cnt;
  logic [GW_W-1:0]  gap_cnt;
  logic [LINES-1:0] mask_q;
  logic             cont_q;

  logic [IDX_W-1:0] adv_idx;
  logic             adv_found;
  logic [IDX_W-1:0] fresh_idx;
  logic             fresh_found;
  logic             dwell_end;
  logic             gap_end;
  logic             do_adv;

  // Next line within the current pass, taken from the latched mask.
  scan_next_idx u_adv (
    .mask      (mask_q),
    .cur       (sel),
    .from_zero (1'b0),
    .idx       (adv_idx),
    .found     (adv_found)
  );

  // First line of a fresh pass, taken from the live mask. This is used at start and at wrap.
  scan_next_idx u_fresh (
    .mask      (mask),
    .cur       (sel),
    .from_zero (1'b1),
    .idx       (fresh_idx),
    .found     (fresh_found)
  );

  // Detect the end of a dwell or blank window; stop overrides any advance.
  always_comb begin
    dwell_end = (state == ACTIVE) && (dwell_cnt >= DWELL_LAST);
    gap_end   = (state == BLANK) && (gap_cnt >= GAP_LAST);
    do_adv    = !stop && ((dwell_end && (GAP == 0)) || gap_end);
  end

  // Scan FSM, together with the counters, the mask/cont latches and the registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      en_n      <= 1'b1;
      sel       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      mask_q    <= '0;
      cont_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (do_adv) begin
        if (adv_found) begin
          sel       <= adv_idx;
          en_n      <= 1'b0;
          dwell_cnt <= '0;
          state     <= ACTIVE;
        end else if (cont_q && fresh_found) begin
          mask_q    <= mask;
          sel       <= fresh_idx;
          en_n      <= 1'b0;
          dwell_cnt <= '0;
          state     <= ACTIVE;
        end else begin
          if (cont_q) mask_q <= mask;
          state <= IDLE;
          en_n  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              mask_q <= mask;
              cont_q <= cont;
              if (fresh_found) begin
                sel       <= fresh_idx;
                en_n      <= 1'b0;
                busy      <= 1'b1;
                dwell_cnt <= '0;
                state     <= ACTIVE;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ACTIVE: begin
            if (stop) begin
              state <= IDLE;
              en_n  <= 1'b1;
              busy  <= 1'b0;
            end else if (dwell_end) begin
              state   <= BLANK;
              en_n    <= 1'b1;
              gap_cnt <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          BLANK: begin
            if (stop) begin
              state <= IDLE;
              en_n  <= 1'b1;
              busy  <= 1'b0;
            end else if (!gap_end) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            en_n  <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with DWELL=2 and GAP=1: a per-cycle vector table plus hand sequences.
// Table row r drives the inputs sampled at edge r and expects the outputs seen just after that edge.
// A model of the active-low 4-to-16 decoder is used to check the full 16-line walk.
module tb_scan_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        cont;
  logic [15:0] mask;
  logic        en_n;
  logic [3:0]  sel;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        start;
    logic        stop;
    logic        cont;
    logic [15:0] mask;
    logic        en_n;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  scan_sequencer #(.DWELL(2), .GAP(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .cont    (cont),
    .mask    (mask),
    .en_n    (en_n),
    .sel     (sel),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_en_n, input logic [3:0] e_sel,
                            input logic e_busy, input logic e_done);
    check({tag, "_en_n"}, 32'(en_n), 32'(e_en_n));
    check({tag, "_sel"},  32'(sel),  32'(e_sel));
    check({tag, "_busy"}, 32'(busy), 32'(e_busy));
    check({tag, "_done"}, 32'(done), 32'(e_done));
  endtask

  //                 start stop cont mask      en_n sel busy done
  task automatic add(input logic s, input logic p, input logic c, input logic [15:0] m,
                     input logic e, input logic [3:0] l, input logic b, input logic d);
    vec_t v;
    v.start = s; v.stop = p; v.cont = c; v.mask = m;
    v.en_n = e; v.sel = l; v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] dec;
    logic [15:0] exp_dec;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    start    = 1'b1;
    stop     = 1'b0;
    cont     = 1'b0;
    mask     = 16'hFFFF;

    // Single pass over lines 0 and 2.
    add(1,0,0,16'h0005, 0, 0, 1, 0);  // row 0
    add(0,0,0,16'h0005, 0, 0, 1, 0);
    add(0,0,0,16'h0005, 1, 0, 1, 0);
    add(0,0,0,16'h0005, 0, 2, 1, 0);
    add(0,0,0,16'h0005, 0, 2, 1, 0);
    add(0,0,0,16'h0005, 1, 2, 1, 0);
    add(0,0,0,16'h0005, 1, 2, 0, 1);  // done pulse
    add(0,0,0,16'h0005, 1, 2, 0, 0);
    // Start with an empty mask: a done pulse and nothing else.
    add(1,0,0,16'h0000, 1, 2, 0, 1);  // row 8
    add(0,0,0,16'h0000, 1, 2, 0, 0);
    // start and stop together in IDLE: the start is ignored.
    add(1,1,0,16'h0005, 1, 2, 0, 0);  // row 10
    add(0,0,0,16'h0005, 1, 2, 0, 0);
    // Continuous scan over 0 and 15, then a mid-pass mask change to line 4.
    add(1,0,1,16'h8001, 0, 0, 1, 0);  // row 12
    add(0,0,0,16'h8001, 0, 0, 1, 0);
    add(0,0,0,16'h8001, 1, 0, 1, 0);
    add(0,0,0,16'h8001, 0, 15, 1, 0);
    add(0,0,0,16'h8001, 0, 15, 1, 0);
    add(0,0,0,16'h8001, 1, 15, 1, 0);
    add(0,0,0,16'h8001, 0, 0, 1, 0);  // wrap
    add(0,0,0,16'h8001, 0, 0, 1, 0);
    add(0,0,0,16'h0010, 1, 0, 1, 0);  // row 20: mask changes mid-pass
    add(0,0,0,16'h0010, 0, 15, 1, 0); // old latch still in force
    add(0,0,0,16'h0010, 0, 15, 1, 0);
    add(0,0,0,16'h0010, 1, 15, 1, 0);
    add(0,0,0,16'h0010, 0, 4, 1, 0);  // wrap picks up the new mask
    add(0,0,0,16'h0010, 0, 4, 1, 0);
    add(0,0,0,16'h0010, 1, 4, 1, 0);
    add(0,0,0,16'h0010, 0, 4, 1, 0);
    add(0,0,0,16'h8001, 0, 4, 1, 0);  // row 28
    add(0,0,0,16'h8001, 1, 4, 1, 0);
    add(0,0,0,16'h8001, 0, 0, 1, 0);
    add(0,0,0,16'h8001, 0, 0, 1, 0);
    add(0,0,0,16'h8001, 1, 0, 1, 0);
    add(0,0,0,16'h8001, 0, 15, 1, 0);
    add(0,0,0,16'h8001, 0, 15, 1, 0); // 2nd dwell cycle of line 15
    add(1,1,0,16'h8001, 1, 15, 0, 0); // row 35: stop, no done pulse
    add(1,1,0,16'h8001, 1, 15, 0, 0); // start+stop in IDLE is ignored
    add(0,0,0,16'h8001, 1, 15, 0, 0);
    // Continuous scan whose wrap finds an empty mask, so it finishes with done.
    add(1,0,1,16'h0002, 0, 1, 1, 0);  // row 38
    add(0,0,0,16'h0000, 0, 1, 1, 0);
    add(0,0,0,16'h0000, 1, 1, 1, 0);
    add(0,0,0,16'h0000, 1, 1, 0, 1);
    add(0,0,0,16'h0000, 1, 1, 0, 0);

    // Reset held with start high: outputs stay at their reset values.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outs($sformatf("reset%0d", i), 1'b1, 4'd0, 1'b0, 1'b0);
    end
    reset_n = 1'b1;
    start   = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      start = vecs[r].start;
      stop  = vecs[r].stop;
      cont  = vecs[r].cont;
      mask  = vecs[r].mask;
      @(posedge clk); #1;
      check_outs($sformatf("row%0d", r), vecs[r].en_n, vecs[r].sel, vecs[r].busy, vecs[r].done);
    end

    // Full single pass over all 16 lines, checked against a decoder model.
    @(negedge clk);
    start = 1'b1; stop = 1'b0; cont = 1'b0; mask = 16'hFFFF;
    for (int j = 1; j <= 50; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      dec = en_n ? 16'hFFFF : ~(16'h0001 << sel);
      if (j <= 48) begin
        exp_dec = (((j - 1) % 3) == 2) ? 16'hFFFF : ~(16'h0001 << ((j - 1) / 3));
        check($sformatf("dec_c%0d", j), 32'(dec), 32'(exp_dec));
        check($sformatf("dec_low_c%0d", j), 32'($countones(~dec)), 32'((((j - 1) % 3) == 2) ? 0 : 1));
      end else if (j == 49) begin
        check_outs("dec_end", 1'b1, 4'd15, 1'b0, 1'b1);
      end else begin
        check("dec_after_done", 32'(done), 32'd0);
      end
    end

    // Reset mid-scan forces the reset values at once, with no done pulse.
    @(negedge clk);
    start = 1'b1; mask = 16'h00F0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midrst_pre_en_n", 32'(en_n), 32'd0);
    check("midrst_pre_sel", 32'(sel), 32'd4);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_outs("midrst", 1'b1, 4'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_outs("midrst_post", 1'b1, 4'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
